perceptron_sum: RTL and testbench



---
 rtl/perceptron_pkg.sv | 41 ++++
 rtl/perceptron_sum.sv | 181 ++++++++++++++++++
 tb/tb_perceptron_sum.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared types, widths and saturation helpers for the perceptron sum stage.
package perceptron_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ARG  = 2'd1,
        DLT  = 2'd2,
        UPD  = 2'd3
    } state_t;

    localparam int ACT_W    = 8;
    localparam int ARG_W    = 16;
    localparam int WGT_W    = 8;
    // Callers sign-extend their operand to this width before saturating.
    localparam int SAT_IN_W = 32;

    function automatic logic signed [WGT_W-1:0] sat8(input logic signed [SAT_IN_W-1:0] v);
        logic signed [WGT_W-1:0] r;
        if (v > 32'sd127) begin
            r = 8'sh7F;
        end else if (v < -32'sd128) begin
            r = 8'sh80;
        end else begin
            r = v[WGT_W-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [ARG_W-1:0] sat16(input logic signed [SAT_IN_W-1:0] v);
        logic signed [ARG_W-1:0] r;
        if (v > 32'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -32'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[ARG_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/perceptron_sum.sv
// Serial weighted sum plus bias with a perceptron weight/bias update in
// training mode; the update walks one weight per cycle.
module perceptron_sum
    import perceptron_pkg::*;
#(
    parameter int N    = 4,
    parameter int RATE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              train,
    input  logic              input_valid,
    input  logic [ACT_W-1:0]  input_data,
    output logic              input_ready,
    output logic              argument_valid,
    output logic [ARG_W-1:0]  argument_data,
    input  logic              argument_ready,
    input  logic              delta_valid,
    input  logic [ARG_W-1:0]  delta_data,
    output logic              delta_ready
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = ARG_W + $clog2(N) + 2;
    localparam int PRD_W = ACT_W + WGT_W + 1;
    localparam int UPD_W = ARG_W + ACT_W + 1;

    state_t                   state_r;
    state_t                   state_next_s;
    logic signed [WGT_W-1:0]  w_r [N];
    logic [ACT_W-1:0]         x_r [N];
    logic signed [ARG_W-1:0]  bias_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [IDX_W-1:0]         idx_r;
    logic                     train_r;
    logic signed [ARG_W-1:0]  delta_r;
    logic                     argument_valid_r;
    logic signed [ARG_W-1:0]  argument_data_r;
    logic                     input_ready_r;
    logic                     delta_ready_r;

    logic                     in_hs_s;
    logic                     arg_hs_s;
    logic                     dlt_hs_s;
    logic                     last_idx_s;
    logic signed [PRD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]  acc_sum_s;
    logic signed [UPD_W-1:0]  upd_prod_s;
    logic signed [UPD_W-1:0]  upd_shift_s;
    logic signed [SAT_IN_W-1:0] w_sum_s;
    logic signed [SAT_IN_W-1:0] bias_sum_s;

    assign input_ready    = input_ready_r;
    assign delta_ready    = delta_ready_r;
    assign argument_valid = argument_valid_r;
    assign argument_data  = argument_data_r;

    assign in_hs_s    = input_valid & input_ready_r;
    assign arg_hs_s   = argument_valid_r & argument_ready;
    assign dlt_hs_s   = delta_valid & delta_ready_r;
    assign last_idx_s = (idx_r == IDX_W'(N - 1));

    // Datapath: MAC term for LOAD and the per-weight / bias update terms for UPD.
    always_comb begin
        prod_s      = $signed(w_r[idx_r]) * $signed({1'b0, input_data});
        acc_sum_s   = acc_r + ACC_W'(prod_s);
        upd_prod_s  = delta_r * $signed({1'b0, x_r[idx_r]});
        upd_shift_s = upd_prod_s >>> RATE;
        w_sum_s     = SAT_IN_W'(w_r[idx_r]) + SAT_IN_W'(upd_shift_s);
        bias_sum_s  = SAT_IN_W'(bias_r) + SAT_IN_W'(delta_r >>> RATE);
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LOAD: begin
                if (in_hs_s && last_idx_s) begin
                    state_next_s = ARG;
                end else begin
                    state_next_s = LOAD;
                end
            end
            ARG: begin
                if (arg_hs_s) begin
                    state_next_s = train ? DLT : LOAD;
                end else begin
                    state_next_s = ARG;
                end
            end
            DLT: begin
                if (dlt_hs_s) begin
                    state_next_s = UPD;
                end else begin
                    state_next_s = DLT;
                end
            end
            UPD: begin
                if (last_idx_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = UPD;
                end
            end
            default: state_next_s = LOAD;
        endcase
    end

    // State, handshake flags and the whole storage set; reset discards any partial sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= LOAD;
            idx_r            <= {IDX_W{1'b0}};
            acc_r            <= {ACC_W{1'b0}};
            bias_r           <= 16'sd0;
            train_r          <= 1'b0;
            delta_r          <= 16'sd0;
            argument_valid_r <= 1'b0;
            argument_data_r  <= 16'sd0;
            input_ready_r    <= 1'b1;
            delta_ready_r    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                w_r[i] <= 8'sd0;
                x_r[i] <= 8'd0;
            end
        end else begin
            state_r       <= state_next_s;
            input_ready_r <= (state_next_s == LOAD);
            delta_ready_r <= (state_next_s == DLT);
            case (state_r)
                LOAD: begin
                    if (in_hs_s) begin
                        x_r[idx_r] <= input_data;
                        acc_r      <= acc_sum_s;
                        if (last_idx_s) begin
                            argument_valid_r <= 1'b1;
                            argument_data_r  <= sat16(SAT_IN_W'(acc_sum_s));
                            idx_r            <= {IDX_W{1'b0}};
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                ARG: begin
                    if (arg_hs_s) begin
                        argument_valid_r <= 1'b0;
                        train_r          <= train;
                        if (!train) begin
                            acc_r <= ACC_W'(bias_r);
                        end
                    end
                end
                DLT: begin
                    if (dlt_hs_s) begin
                        delta_r <= $signed(delta_data);
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                UPD: begin
                    // Only a sample latched as training may touch the weights.
                    if (train_r) begin
                        w_r[idx_r] <= sat8(w_sum_s);
                        if (idx_r == {IDX_W{1'b0}}) begin
                            bias_r <= sat16(bias_sum_s);
                        end
                    end
                    if (last_idx_s) begin
                        idx_r <= {IDX_W{1'b0}};
                        acc_r <= ACC_W'(bias_r);
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_sum.sv
// Self-checking bench for perceptron_sum: directed scenarios plus random samples
// checked against an integer-arithmetic perceptron model.
module tb_perceptron_sum;

    localparam int N    = 4;
    localparam int RATE = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        train = 1'b0;
    logic        input_valid = 1'b0;
    logic [7:0]  input_data = 8'd0;
    logic        input_ready;
    logic        argument_valid;
    logic [15:0] argument_data;
    logic        argument_ready = 1'b0;
    logic        delta_valid = 1'b0;
    logic [15:0] delta_data = 16'd0;
    logic        delta_ready;

    int n_vec  = 0;
    int n_fail = 0;

    int w_m [N];
    int bias_m;
    logic [7:0]  last_x [N];
    logic [15:0] got;

    bit watch_dr = 1'b0;
    bit dr_seen  = 1'b0;

    perceptron_sum #(.N(N), .RATE(RATE)) dut (
        .clock          (clock),
        .reset          (reset),
        .train          (train),
        .input_valid    (input_valid),
        .input_data     (input_data),
        .input_ready    (input_ready),
        .argument_valid (argument_valid),
        .argument_data  (argument_data),
        .argument_ready (argument_ready),
        .delta_valid    (delta_valid),
        .delta_data     (delta_data),
        .delta_ready    (delta_ready)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (watch_dr && delta_ready === 1'b1) dr_seen = 1'b1;
    end

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [15:0] expected_sum(input logic [7:0] xs [N]);
        int s;
        s = bias_m;
        for (int i = 0; i < N; i++) s += w_m[i] * int'(xs[i]);
        return 16'(clamp(s, -32768, 32767));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) w_m[i] = 0;
        bias_m = 0;
    endtask

    task automatic model_update(input logic [7:0] xs [N], input logic [15:0] d);
        int dv;
        dv = int'($signed(d));
        for (int i = 0; i < N; i++) w_m[i] = clamp(w_m[i] + ((dv * int'(xs[i])) >>> RATE), -128, 127);
        bias_m = clamp(bias_m + (dv >>> RATE), -32768, 32767);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Streams one sample and checks the argument appears exactly one cycle after the last beat.
    task automatic load_and_check(input logic [7:0] xs [N], output logic [15:0] res);
        logic [15:0] exp_v;
        int cnt;
        exp_v = expected_sum(xs);
        for (int i = 0; i < N; i++) begin
            @(negedge clock);
            input_valid = 1'b1;
            input_data  = xs[i];
            cnt = 0;
            while (input_ready !== 1'b1 && cnt < 100) begin
                @(negedge clock);
                cnt++;
            end
            n_vec++;
            if (cnt >= 100) begin
                n_fail++;
                $display("FAIL beat_ready beat=%0d: input_ready=%b, required 1 within 100 cycles", i, input_ready);
            end
            n_vec++;
            if (argument_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL early_arg beat=%0d: argument_valid=%b, required 0", i, argument_valid);
            end
            @(posedge clock);
        end
        last_x = xs;
        @(negedge clock);
        input_valid = 1'b0;
        n_vec++;
        if (argument_valid !== 1'b1 || argument_data !== exp_v || input_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arg_out: valid=%b data=%h in_ready=%b, required valid=1 data=%h in_ready=0",
                     argument_valid, argument_data, input_ready, exp_v);
        end
        res = argument_data;
    endtask

    // Holds off the argument for 'hold' cycles, then accepts it with the given train value.
    task automatic accept_arg(input bit tr, input int hold);
        logic [15:0] d0;
        d0 = argument_data;
        argument_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clock);
            @(negedge clock);
            n_vec++;
            if (argument_valid !== 1'b1 || argument_data !== d0 || input_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL arg_hold k=%0d: valid=%b data=%h in_ready=%b, required 1 %h 0",
                         k, argument_valid, argument_data, input_ready, d0);
            end
        end
        argument_ready = 1'b1;
        train = tr;
        @(posedge clock);
        @(negedge clock);
        argument_ready = 1'b0;
        train = ~tr;
        n_vec++;
        if (argument_valid !== 1'b0 || input_ready !== !tr || delta_ready !== tr) begin
            n_fail++;
            $display("FAIL arg_accept train=%b: valid=%b in_ready=%b d_ready=%b, required 0 %b %b",
                     tr, argument_valid, input_ready, delta_ready, !tr, tr);
        end
    endtask

    // Hands over a delta; with full=1 also waits out the N update cycles.
    task automatic deliver_delta(input logic [15:0] d, input bit full);
        int cnt;
        cnt = 0;
        while (delta_ready !== 1'b1 && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        n_vec++;
        if (cnt >= 100) begin
            n_fail++;
            $display("FAIL delta_ready_wait: delta_ready=%b, required 1", delta_ready);
        end
        delta_valid = 1'b1;
        delta_data  = d;
        @(posedge clock);
        @(negedge clock);
        delta_valid = 1'b0;
        n_vec++;
        if (delta_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL delta_drop: delta_ready=%b, required 0", delta_ready);
        end
        model_update(last_x, d);
        if (full) begin
            for (int k = 0; k < N; k++) begin
                n_vec++;
                if (input_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL upd_busy k=%0d: input_ready=%b, required 0", k, input_ready);
                end
                @(negedge clock);
            end
            n_vec++;
            if (input_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL upd_done: input_ready=%b, required 1", input_ready);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (input_ready !== 1'b1 || argument_valid !== 1'b0 || delta_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b arg_valid=%b d_ready=%b, required 1 0 0",
                     input_ready, argument_valid, delta_ready);
        end
    endtask

    task automatic test_untrained_sum();
        logic [7:0] xs [N] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        load_and_check(xs, got);
        n_vec++;
        if (got !== 16'h0000) begin
            n_fail++;
            $display("FAIL untrained_sum: got %h, required 0000", got);
        end
        accept_arg(1'b0, 0);
    endtask

    task automatic test_positive_update();
        logic [7:0] xs [N] = '{8'hFF, 8'h00, 8'h80, 8'h01};
        logic [7:0] ones [N] = '{8'h01, 8'h01, 8'h01, 8'h01};
        load_and_check(xs, got);
        accept_arg(1'b1, 0);
        deliver_delta(16'h0100, 1'b1);
        load_and_check(ones, got);
        n_vec++;
        if (got !== 16'h011E) begin
            n_fail++;
            $display("FAIL positive_update: got %h, required 011E", got);
        end
        accept_arg(1'b0, 0);
    endtask

    task automatic test_ignored_delta();
        logic [7:0] ones [N] = '{8'h01, 8'h01, 8'h01, 8'h01};
        delta_valid = 1'b1;
        delta_data  = 16'h7FFF;
        dr_seen     = 1'b0;
        watch_dr    = 1'b1;
        load_and_check(ones, got);
        accept_arg(1'b0, 1);
        load_and_check(ones, got);
        accept_arg(1'b0, 0);
        watch_dr    = 1'b0;
        delta_valid = 1'b0;
        n_vec++;
        if (dr_seen !== 1'b0 || got !== 16'h011E) begin
            n_fail++;
            $display("FAIL ignored_delta: delta_ready_seen=%b sum=%h, required 0 011E", dr_seen, got);
        end
    endtask

    task automatic test_negative_saturation();
        logic [7:0] ff [N] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_reset();
        load_and_check(ff, got);
        accept_arg(1'b1, 0);
        deliver_delta(16'hF000, 1'b1);
        load_and_check(ff, got);
        n_vec++;
        if (got !== 16'h8000) begin
            n_fail++;
            $display("FAIL negative_saturation: got %h, required 8000", got);
        end
        accept_arg(1'b0, 0);
    endtask

    task automatic test_reset_mid_upd();
        logic [7:0] ff [N] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        load_and_check(ff, got);
        accept_arg(1'b1, 0);
        deliver_delta(16'h0300, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        n_vec++;
        if (input_ready !== 1'b1 || argument_valid !== 1'b0 || delta_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_upd: in_ready=%b arg_valid=%b d_ready=%b, required 1 0 0",
                     input_ready, argument_valid, delta_ready);
        end
        load_and_check(ff, got);
        n_vec++;
        if (got !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_upd_sum: got %h, required 0000", got);
        end
        accept_arg(1'b0, 0);
    endtask

    task automatic test_backpressure();
        logic [7:0] xs [N] = '{8'h10, 8'h20, 8'h30, 8'h40};
        load_and_check(xs, got);
        accept_arg(1'b0, 5);
    endtask

    task automatic test_random();
        logic [7:0] xs [N];
        bit tr;
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < N; i++) xs[i] = 8'($urandom_range(0, 255));
            tr = 1'($urandom_range(0, 1));
            load_and_check(xs, got);
            accept_arg(tr, $urandom_range(0, 3));
            if (tr) deliver_delta(16'($urandom_range(0, 65535)), 1'b1);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_untrained_sum();
        test_positive_update();
        test_ignored_delta();
        test_negative_saturation();
        test_reset_mid_upd();
        test_backpressure();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
